cover_toggle_collector: RTL and testbench
=========================================

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 28, the number of monitored signal bits (1..1024).
REQ-002 The block SHALL have parameter COVER_INDEX, default 0, the global cover index of point 0.
REQ-003 The block SHALL have parameter COVER_TOTAL, default 10906, the global point count; COVER_INDEX + POINTS <= COVER_TOTAL is checked at elaboration.
REQ-004 The block SHALL have port clock, input, 1, the sole clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port valid, input, WIDTH, the monitored signal vector.
REQ-007 The block SHALL have port sample_en, input, 1, which enables toggle detection in the current cycle.
REQ-008 The block SHALL have port clear, input, 1, a synchronous clear of all coverage state.
REQ-009 The block SHALL have port ev_valid, output, 1, which flags that an event is presented.
REQ-010 The block SHALL have port ev_ready, input, 1, the consumer's acceptance of the presented event.
REQ-011 The block SHALL have port ev_index, output, 64, the global index (COVER_INDEX + point) of the presented event.
REQ-012 The block SHALL have port covered_count, output, clog2(POINTS+1), the number of distinct points hit.
REQ-013 The block SHALL have port all_covered, output, 1, asserted when covered_count == POINTS.

Function
REQ-014 The block SHALL use point i (i < WIDTH) as the rise of valid[i] (0->1 between consecutive sampled cycles); POINTS = WIDTH without TOGGLE_FALL_EN.
REQ-015 The block SHALL register the previous sample of valid and a "primed" flag on every cycle with sample_en=1.
REQ-016 The block SHALL detect a toggle only when sample_en=1 and primed=1; the first sampled cycle after reset or clear only primes.
REQ-017 When a point is detected with hit=0, the block SHALL set the sticky hit bit and the pending bit at the next edge, and SHALL ignore later detections of that point.
REQ-018 The block SHALL increment covered_count by the popcount of newly hit points in the same edge, so multiple points are counted per cycle.
REQ-019 The output stage SHALL be two-state: EMPTY (ev_valid=0) and HOLD (ev_valid=1).
REQ-020 In EMPTY with any pending bit set, the block SHALL load the lowest-index pending point, clear its pending bit, and move to HOLD.
REQ-021 In HOLD, ev_index SHALL remain stable until ev_valid&ev_ready.
REQ-022 On acceptance, the block SHALL load the next lowest pending point in the same edge (back-to-back, one event per cycle) or return to EMPTY.
REQ-023 Latency from the toggle-observing cycle to ev_valid SHALL be 2 edges when the stage is EMPTY.
REQ-024 Detection and drain in the same cycle SHALL both take effect; a point hit in the loading cycle is not lost.
REQ-025 clear=1 SHALL zero hit, pending, covered_count, primed and ev_valid at the next edge, SHALL override a simultaneous detection or acceptance, and SHALL not produce a partial event.
REQ-026 Every point SHALL be reported exactly once between clears.

Reset
REQ-027 Asserting reset (low) SHALL immediately zero hit, pending, prev sample, primed and covered_count, and force ev_valid=0, ev_index=0 and all_covered=0.
REQ-028 Reset asserted mid-HOLD SHALL discard the presented event with no report.

Configuration
REQ-029 With TOGGLE_FALL_EN defined, the block SHALL add points WIDTH+i for the falls (1->0) of valid[i], making POINTS = 2*WIDTH, with the same rules.
REQ-030 Without TOGGLE_FALL_EN, fall detection logic and state SHALL be absent and POINTS = WIDTH.

Structure
REQ-031 Package cover_pkg SHALL hold COVER_INDEX_W=64, the points_of(WIDTH) function and the ev state enum {EMPTY, HOLD}.
REQ-032 The block SHALL contain one sub-module, cover_lowest_pending: a parametrised priority encoder returning the found flag and the index of the lowest set bit.

Verification
REQ-033 Reset, one sample_en cycle with valid=0, then valid=28'h1 -> ev_valid at +2 edges, ev_index=COVER_INDEX+0, covered_count=1.
REQ-034 valid 0 -> 28'hFFFFFFF in one cycle with ev_ready=1 -> 28 events, indices 0..27 ascending on consecutive cycles, all_covered=1 (rise-only build).
REQ-035 ev_ready=0 for 10 cycles while bit 5 then bit 2 toggle -> ev_index holds 5; after acceptance 2 follows, with no duplicates.
REQ-036 Repeated toggling of bit 3 -> exactly one event for point 3; covered_count stays 1.
REQ-037 clear asserted in the same cycle as a new toggle and ev acceptance -> next cycle count=0, ev_valid=0, and no event for that toggle.
REQ-038 TOGGLE_FALL_EN build: bit 0 goes 0->1->0 -> events 0 then 28, and covered_count=2.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared types and sizing helpers for the toggle-coverage collector.
// Defining TOGGLE_FALL_EN doubles the point space to include falling edges.
package cover_pkg;

    localparam int COVER_INDEX_W = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } ev_state_t;

    function automatic int points_of(input int width);
`ifdef TOGGLE_FALL_EN
        return 2 * width;
`else
        return width;
`endif
    endfunction

    // Index width that stays legal for a single-point instance.
    function automatic int index_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cover_lowest_pending.sv
// Priority encoder: reports whether any bit is set and the index of the lowest one.
module cover_lowest_pending #(
    parameter int N  = 28,
    parameter int IW = 5
) (
    input  logic [N-1:0]  bits,
    output logic          found,
    output logic [IW-1:0] index
);

    // Scan from the top so the last match written is the lowest set bit.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records first rise (and, with TOGGLE_FALL_EN, first fall)
// of each monitored bit and reports each point once through a valid/ready event port.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 10906,
    localparam int POINTS     = points_of(WIDTH),
    localparam int CNT_W      = $clog2(POINTS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         valid,
    input  logic                     sample_en,
    input  logic                     clear,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [COVER_INDEX_W-1:0] ev_index,
    output logic [CNT_W-1:0]         covered_count,
    output logic                     all_covered
);

    localparam int IW = index_w(POINTS);

    generate
        if (COVER_INDEX + POINTS > COVER_TOTAL) begin : g_range_check
            $error("cover_toggle_collector: COVER_INDEX + POINTS exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0]         prev_reg;
    logic                     primed_reg;
    logic [POINTS-1:0]        hit_reg;
    logic [POINTS-1:0]        pending_reg;
    logic [POINTS-1:0]        pending_next;
    logic [POINTS-1:0]        det;
    logic [POINTS-1:0]        new_hit;
    logic [POINTS-1:0]        load_mask;
    logic [CNT_W-1:0]         count_reg;
    logic [CNT_W-1:0]         new_cnt;
    ev_state_t                state_reg;
    ev_state_t                state_next;
    logic [COVER_INDEX_W-1:0] ev_index_reg;
    logic [COVER_INDEX_W-1:0] ev_index_next;
    logic                     found;
    logic [IW-1:0]            low_idx;
    logic                     load;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_detect
            assign det[gi] = sample_en & primed_reg & ~prev_reg[gi] & valid[gi];
`ifdef TOGGLE_FALL_EN
            assign det[WIDTH + gi] = sample_en & primed_reg & prev_reg[gi] & ~valid[gi];
`endif
        end
    endgenerate

    // Only first-time detections matter; the hit bits make every point sticky.
    assign new_hit = det & ~hit_reg;

    always_comb begin
        new_cnt = '0;
        for (int i = 0; i < POINTS; i++) begin
            new_cnt = new_cnt + CNT_W'(new_hit[i]);
        end
    end

    cover_lowest_pending #(
        .N  (POINTS),
        .IW (IW)
    ) u_lowest (
        .bits  (pending_reg),
        .found (found),
        .index (low_idx)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ev_ready) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // The drain only looks at already-registered pending bits, so fresh hits are
    // merged in after the loaded bit is removed and can never be lost.
    always_comb begin
        load_mask     = load ? (POINTS'(1) << low_idx) : '0;
        pending_next  = (pending_reg & ~load_mask) | new_hit;
        ev_index_next = load ? (COVER_INDEX_W'(COVER_INDEX) + COVER_INDEX_W'(low_idx))
                             : ev_index_reg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_reg     <= '0;
            primed_reg   <= 1'b0;
            hit_reg      <= '0;
            pending_reg  <= '0;
            count_reg    <= '0;
            state_reg    <= EMPTY;
            ev_index_reg <= '0;
        end else if (clear) begin
            primed_reg   <= 1'b0;
            hit_reg      <= '0;
            pending_reg  <= '0;
            count_reg    <= '0;
            state_reg    <= EMPTY;
        end else begin
            hit_reg      <= hit_reg | new_hit;
            pending_reg  <= pending_next;
            count_reg    <= count_reg + new_cnt;
            state_reg    <= state_next;
            ev_index_reg <= ev_index_next;
            if (sample_en) begin
                prev_reg   <= valid;
                primed_reg <= 1'b1;
            end
        end
    end

    assign ev_valid      = (state_reg == HOLD);
    assign ev_index      = ev_index_reg;
    assign covered_count = count_reg;
    assign all_covered   = (count_reg == CNT_W'(POINTS));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Self-checking bench for cover_toggle_collector: directed scenarios plus random
// toggling, compared each cycle against a point-set reference model.
module tb_cover_toggle_collector;

    localparam int W  = 28;
    localparam int CI = 100;
`ifdef TOGGLE_FALL_EN
    localparam int P  = 2 * W;
`else
    localparam int P  = W;
`endif
    localparam int CW = $clog2(P + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  valid = '0;
    logic          sample_en = 1'b0;
    logic          clear = 1'b0;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [63:0]   ev_index;
    logic [CW-1:0] covered_count;
    logic          all_covered;

    cover_toggle_collector #(
        .WIDTH       (W),
        .COVER_INDEX (CI),
        .COVER_TOTAL (10906)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .valid         (valid),
        .sample_en     (sample_en),
        .clear         (clear),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_index      (ev_index),
        .covered_count (covered_count),
        .all_covered   (all_covered)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sets of hit / awaiting-report points and the presented event.
    bit          m_hit  [P];
    bit          m_pend [P];
    bit [W-1:0]  m_prev;
    bit          m_primed;
    bit          m_valid;
    longint      m_idx;
    int          m_count;
    int          rep_cnt [P];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) begin
            m_hit[p]   = 1'b0;
            m_pend[p]  = 1'b0;
            rep_cnt[p] = 0;
        end
        m_prev   = '0;
        m_primed = 1'b0;
        m_valid  = 1'b0;
        m_idx    = 0;
        m_count  = 0;
    endtask

    function automatic int lowest_pending();
        for (int p = 0; p < P; p++) begin
            if (m_pend[p]) return p;
        end
        return -1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ev_valid"}, 64'(ev_valid), 64'(m_valid));
        if (m_valid) chk({tag, ".ev_index"}, ev_index, 64'(m_idx));
        chk({tag, ".count"}, 64'(covered_count), 64'(m_count));
        chk({tag, ".all_covered"}, 64'(all_covered), 64'(m_count == P));
    endtask

    task automatic step(input string tag, input logic [W-1:0] v, input bit se,
                        input bit clr, input bit rdy);
        bit newh [P];
        int lo;
        int ai;
        valid     = v;
        sample_en = se;
        clear     = clr;
        ev_ready  = rdy;
        if (ev_valid === 1'b1 && rdy && !clr) begin
            ai = int'(ev_index) - CI;
            if (ai >= 0 && ai < P) rep_cnt[ai]++;
        end
        if (clr) begin
            for (int p = 0; p < P; p++) begin
                m_hit[p]   = 1'b0;
                m_pend[p]  = 1'b0;
                rep_cnt[p] = 0;
            end
            m_primed = 1'b0;
            m_valid  = 1'b0;
            m_count  = 0;
        end else begin
            for (int p = 0; p < P; p++) newh[p] = 1'b0;
            if (se && m_primed) begin
                for (int i = 0; i < W; i++) begin
                    if (!m_prev[i] && v[i]) newh[i] = 1'b1;
`ifdef TOGGLE_FALL_EN
                    if (m_prev[i] && !v[i]) newh[W + i] = 1'b1;
`endif
                end
            end
            lo = lowest_pending();
            if (!m_valid || rdy) begin
                if (lo >= 0) begin
                    m_valid   = 1'b1;
                    m_idx     = CI + lo;
                    m_pend[lo] = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int p = 0; p < P; p++) begin
                if (newh[p] && !m_hit[p]) begin
                    m_hit[p]  = 1'b1;
                    m_pend[p] = 1'b1;
                    m_count++;
                end
            end
            if (se) begin
                m_prev   = v;
                m_primed = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] ones;
        bit se, clr, rdy;
        ones = '1;
        model_reset();

        // Reset state while reset is held low
        repeat (2) @(posedge clock);
        #1;
        chk("reset.ev_valid", 64'(ev_valid), 64'd0);
        chk("reset.ev_index", ev_index, 64'd0);
        chk("reset.count", 64'(covered_count), 64'd0);
        chk("reset.all_covered", 64'(all_covered), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single rise: ev_valid two edges after the observing cycle
        step("prime", '0, 1, 0, 0);
        step("rise0", W'(1), 1, 0, 0);
        chk("lat.edge1_no_ev", 64'(ev_valid), 64'd0);
        step("rise0_hold", W'(1), 1, 0, 0);
        chk("lat.edge2_ev", 64'(ev_valid), 64'd1);
        chk("lat.index", ev_index, 64'(CI + 0));
        chk("lat.count", 64'(covered_count), 64'd1);
        step("accept0", W'(1), 1, 0, 1);
        chk("accept0.empty", 64'(ev_valid), 64'd0);

        // Repeated toggling of bit 3 reports point 3 only once
        v = W'(1);
        for (int k = 0; k < 6; k++) begin
            v = v ^ W'(8);
            step("toggle3", v, 1, 0, 1);
        end
        repeat (4) step("idle3", v, 1, 0, 1);
        chk("toggle3.reports", 64'(rep_cnt[3]), 64'd1);
`ifndef TOGGLE_FALL_EN
        chk("toggle3.count", 64'(covered_count), 64'd2);
`endif

        // Back-pressure: point 5 is held while point 2 waits behind it
        v = v | W'(32);
        step("rise5", v, 1, 0, 0);
        v = v | W'(4);
        step("rise2", v, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step("stall", v, 1, 0, 0);
            chk("stall.index5", ev_index, 64'(CI + 5));
        end
        step("accept5", v, 1, 0, 1);
        chk("after5.index2", ev_index, 64'(CI + 2));
        step("accept2", v, 1, 0, 1);
        repeat (2) step("drain", v, 1, 0, 1);
        chk("rep5.once", 64'(rep_cnt[5]), 64'd1);
        chk("rep2.once", 64'(rep_cnt[2]), 64'd1);

        // Clear overrides a simultaneous toggle and acceptance
        v = v | W'(32'h180);
        step("rise78", v, 1, 0, 0);
        step("hold7", v, 1, 0, 0);
        step("clear", v | W'(32'h200), 1, 1, 1);
        chk("clear.count", 64'(covered_count), 64'd0);
        chk("clear.ev_valid", 64'(ev_valid), 64'd0);
        v = v | W'(32'h200);
        repeat (4) step("post_clear", v, 1, 0, 1);
        chk("clear.no_ev9", 64'(rep_cnt[9]), 64'd0);
        chk("clear.stays_empty", 64'(ev_valid), 64'd0);

        // All bits rise together: ascending back-to-back events
        step("clear2", '0, 1, 1, 1);
        step("zero", '0, 1, 0, 1);
        step("all_rise", ones, 1, 0, 1);
`ifndef TOGGLE_FALL_EN
        chk("all.count", 64'(covered_count), 64'(W));
        chk("all.covered", 64'(all_covered), 64'd1);
`endif
        for (int k = 0; k < W; k++) begin
            step("burst", ones, 1, 0, 1);
`ifndef TOGGLE_FALL_EN
            chk("burst.valid", 64'(ev_valid), 64'd1);
            chk("burst.index", ev_index, 64'(CI + k));
`endif
        end
        repeat (P - W + 2) step("burst_end", ones, 1, 0, 1);
        chk("burst.done", 64'(ev_valid), 64'd0);

`ifdef TOGGLE_FALL_EN
        // Rise then fall of bit 0 reports points 0 and WIDTH
        step("fclear", '0, 1, 1, 1);
        step("fprime", '0, 1, 0, 1);
        step("frise", W'(1), 1, 0, 1);
        step("ffall", '0, 1, 0, 1);
        chk("fall.first", ev_index, 64'(CI + 0));
        step("fnext", '0, 1, 0, 1);
        chk("fall.second", ev_index, 64'(CI + W));
        chk("fall.count", 64'(covered_count), 64'd2);
        step("fdone", '0, 1, 0, 1);
`endif

        // Random toggling against the model
        step("rclear", '0, 1, 1, 1);
        v = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) v = v ^ (W'(1) << $urandom_range(0, W - 1));
            se  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 4) < 3);
            step("rand", v, se, clr, rdy);
        end
        repeat (P + 4) step("rdrain", v, 0, 0, 1);
        for (int p = 0; p < P; p++) begin
            chk("rand.once", 64'(rep_cnt[p]), 64'(m_hit[p] ? 1 : 0));
        end

        // Reset in HOLD discards the presented event immediately
        step("hclear", '0, 1, 1, 0);
        step("hprime", '0, 1, 0, 0);
        step("hrise", W'(3), 1, 0, 0);
        step("hhold", W'(3), 1, 0, 0);
        chk("hold.before_reset", 64'(ev_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("midreset.ev_valid", 64'(ev_valid), 64'd0);
        chk("midreset.ev_index", ev_index, 64'd0);
        chk("midreset.count", 64'(covered_count), 64'd0);
        chk("midreset.all_covered", 64'(all_covered), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (5) step("after_reset", W'(3), 1, 0, 1);
        chk("after_reset.no_event", 64'(ev_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
